// File: rtl/spi_port_master_if.sv
// Z80-style CPU I/O bus as seen by the SPI port master.
interface spi_port_master_if;
   logic [7:0] a;
   logic       iorq_n;
   logic       rd_n;
   logic       wr_n;
   logic [7:0] din;
   logic [7:0] dout;
   logic       oe_n;

   modport master (output a, iorq_n, rd_n, wr_n, din, input dout, oe_n);
   modport slave  (input a, iorq_n, rd_n, wr_n, din, output dout, oe_n);
endinterface

// File: rtl/spi_port_master.sv
// Z80 I/O-mapped SPI master: data, chip-select, mode/status and divider ports,
// one byte per transfer, MSB first, CPOL/CPHA selectable.
module spi_port_master #(
   parameter int         NUM_CS    = 1,
   parameter logic [7:0] PORT_DATA = 8'hEB,
   parameter logic [7:0] PORT_CS   = 8'hE7,
   parameter logic [7:0] PORT_CFG  = 8'hEF,
   parameter logic [7:0] PORT_DIV  = 8'hF3,
   parameter logic [7:0] DIV_RESET = 8'd0
) (
   input  logic              clk,
   input  logic              rst,
   spi_port_master_if.slave  bus,
   output logic [NUM_CS-1:0] spi_cs_n,
   output logic              spi_sck,
   output logic              spi_mosi,
   input  logic              spi_miso
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0] state;
   logic [7:0] pre, div, tx, rx, rx_last;
   logic [4:0] cnt;
   logic       phase, cpol, cpha, overrun, acc_q;

   logic io, wr_data, rd_data, wr_cs, wr_cfg, rd_cfg, wr_div;
   logic acc_data, trig, busy, lead, do_sample, do_shift;

   assign io       = !bus.iorq_n;
   assign wr_data  = io && !bus.wr_n && (bus.a == PORT_DATA);
   assign rd_data  = io && !bus.rd_n && (bus.a == PORT_DATA);
   assign wr_cs    = io && !bus.wr_n && (bus.a == PORT_CS);
   assign wr_cfg   = io && !bus.wr_n && (bus.a == PORT_CFG);
   assign rd_cfg   = io && !bus.rd_n && (bus.a == PORT_CFG);
   assign wr_div   = io && !bus.wr_n && (bus.a == PORT_DIV);
   assign acc_data = wr_data || rd_data;
   // Only the first decoded cycle of a data access starts a transfer.
   assign trig     = acc_data && !acc_q;
   assign busy     = (state != IDLE);

   // cnt holds edges already done, so the upcoming edge is odd (leading) when cnt is even.
   assign lead      = ~cnt[0];
   assign do_sample = cpha ? !lead : lead;
   assign do_shift  = cpha ? (lead && (cnt != 5'd0)) : !lead;

   assign spi_sck  = (state == SHIFT) ? (phase ^ cpol) : cpol;
   assign spi_mosi = tx[7];
   assign bus.oe_n = !(rd_data || rd_cfg);
   assign bus.dout = rd_cfg ? {busy, overrun, 4'b0000, cpol, cpha} : rx_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         spi_cs_n <= '1;
         phase    <= 1'b0;
         cpol     <= 1'b0;
         cpha     <= 1'b0;
         div      <= DIV_RESET;
         tx       <= 8'hFF;
         rx       <= 8'hFF;
         rx_last  <= 8'hFF;
         overrun  <= 1'b0;
         pre      <= 8'd0;
         cnt      <= 5'd0;
         acc_q    <= 1'b0;
      end else begin
         acc_q <= acc_data;
         if (wr_cs)  spi_cs_n <= bus.din[NUM_CS-1:0];
         if (wr_div) div      <= bus.din;
         if (wr_cfg) begin
            cpha <= bus.din[0];
            cpol <= bus.din[1];
            if (bus.din[7]) overrun <= 1'b0;
         end
         if (trig && busy) overrun <= 1'b1;

         case (state)
            IDLE: if (trig) begin
               tx    <= wr_data ? bus.din : 8'hFF;
               pre   <= 8'd0;
               cnt   <= 5'd0;
               phase <= 1'b0;
               state <= SHIFT;
            end
            SHIFT: begin
               // >= keeps a divider lowered mid-transfer from running pre through 255.
               if (pre >= div) begin
                  pre   <= 8'd0;
                  phase <= ~phase;
                  cnt   <= cnt + 5'd1;
                  if (do_sample) rx <= {rx[6:0], spi_miso};
                  if (do_shift)  tx <= {tx[6:0], 1'b1};
                  if (cnt == 5'd15) state <= DONE;
               end else begin
                  pre <= pre + 8'd1;
               end
            end
            DONE: begin
               rx_last <= rx;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
